// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants and FSM encoding for the fetch stage
package fetch_unit_pkg;

    // Memory transfer direction
    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    // Byte-lane frame masks
    localparam logic [3:0] WORD = 4'b1111;
    localparam logic [3:0] NONE = 4'b0000;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

    // PC the pipeline loads on reset; the first sequential next_PC wraps to 0
    localparam logic [31:0] RESET_ADDRESS = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: next-PC selection, word read request, fetched-word capture
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN (adds fetch_misaligned output).
// Ports:
//   CLK, reset                     clock, synchronous active-high reset
//   enable                         fetch enable (0 stalls)
//   PC, address, jump_branch_enable current PC, redirect target, redirect strobe
//   next_PC                        PC for the next cycle
//   fetched_instruction            last completed fetch word
//   memory_interface_*             word-read request / response
//   fetch_misaligned               PC[1:0] != 0 while fetching (FETCH_ALIGN_CHECK_EN only)
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic        CLK,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] PC,
    input  logic [31:0] address,
    input  logic        jump_branch_enable,
    output logic [31:0] next_PC,
    output logic [31:0] fetched_instruction,
    output logic        memory_interface_enable,
    output logic        memory_interface_memory_state,
    output logic [31:0] memory_interface_address,
    output logic [3:0]  memory_interface_frame_mask,
    input  logic [31:0] memory_interface_data,
    input  logic        memory_interface_memory_done
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        fetch_misaligned
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetched_q, fetched_d;
    logic         misaligned;

    // Next PC does not depend on enable or reset; 32-bit add wraps naturally.
    assign next_PC = jump_branch_enable ? address : (PC + 32'd4);

    assign memory_interface_memory_state = READ;
    assign memory_interface_address      = PC;
    assign fetched_instruction           = fetched_q;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned       = (state_q == ST_FETCH) && (PC[1:0] != 2'b00) && !reset;
    assign fetch_misaligned = misaligned;
`else
    assign misaligned = 1'b0;
`endif

    // State and fetched-word registers
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            fetched_q <= NOP_INSTRUCTION;
        end else begin
            state_q   <= state_d;
            fetched_q <= fetched_d;
        end
    end

    // Next state and capture. Priority inside FETCH: stall, then redirect,
    // then misalignment, then a completed transfer. Data is only looked at
    // when done is high, so X/Z on the bus elsewhere never reaches the register.
    always_comb begin
        state_d   = state_q;
        fetched_d = fetched_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (jump_branch_enable) begin
                    state_d   = ST_FLUSH;
                    fetched_d = NOP_INSTRUCTION;
                end else if (misaligned) begin
                    fetched_d = NOP_INSTRUCTION;
                end else if (memory_interface_memory_done) begin
                    fetched_d = memory_interface_data;
                end
            end
            ST_FLUSH: begin
                fetched_d = NOP_INSTRUCTION;
                state_d   = enable ? ST_FETCH : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request outputs; reset gates them immediately, before the state register clears.
    always_comb begin
        memory_interface_enable     = (state_q == ST_FETCH) && !reset && !misaligned;
        memory_interface_frame_mask = memory_interface_enable ? WORD : NONE;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] PC;
    logic [31:0] address;
    logic        jump_branch_enable;
    logic [31:0] next_PC;
    logic [31:0] fetched_instruction;
    logic        memory_interface_enable;
    logic        memory_interface_memory_state;
    logic [31:0] memory_interface_address;
    logic [3:0]  memory_interface_frame_mask;
    logic [31:0] memory_interface_data;
    logic        memory_interface_memory_done;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_misaligned;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 CLK = ~CLK;

    fetch_unit dut (
        .CLK                           (CLK),
        .reset                         (reset),
        .enable                        (enable),
        .PC                            (PC),
        .address                       (address),
        .jump_branch_enable            (jump_branch_enable),
        .next_PC                       (next_PC),
        .fetched_instruction           (fetched_instruction),
        .memory_interface_enable       (memory_interface_enable),
        .memory_interface_memory_state (memory_interface_memory_state),
        .memory_interface_address      (memory_interface_address),
        .memory_interface_frame_mask   (memory_interface_frame_mask),
        .memory_interface_data         (memory_interface_data),
        .memory_interface_memory_done  (memory_interface_memory_done)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_misaligned              (fetch_misaligned)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; PC = 32'hFFFF_FFFC; address = 32'h0;
        jump_branch_enable = 1'b0;
        memory_interface_data = 32'hx; memory_interface_memory_done = 1'b0;
        #1;
        check("rst_comb_men", {31'b0, memory_interface_enable}, 32'h0);

        // Reset held two cycles
        tick(); tick();
        check("rst_fetched", fetched_instruction, NOP);
        check("rst_men", {31'b0, memory_interface_enable}, 32'h0);
        check("rst_mask", {28'b0, memory_interface_frame_mask}, 32'h0);
        check("rst_next_pc_wrap", next_PC, 32'h0);

        // Leave reset, go to FETCH at PC=0
        reset = 1'b0; PC = 32'h0;
        tick();
        check("fetch_men", {31'b0, memory_interface_enable}, 32'h1);
        check("fetch_mask", {28'b0, memory_interface_frame_mask}, 32'hF);
        check("fetch_addr", memory_interface_address, 32'h0);
        check("fetch_rw", {31'b0, memory_interface_memory_state}, 32'h0);
        check("fetch_no_capture_yet", fetched_instruction, NOP);
        memory_interface_data = 32'h0050_0093; memory_interface_memory_done = 1'b1;
        tick();
        check("capture1", fetched_instruction, 32'h0050_0093);
        memory_interface_data = 32'hx; memory_interface_memory_done = 1'b0;

        // Sequential next PC
        PC = 32'h4; #1; check("seq_4", next_PC, 32'h8);
        PC = 32'h8; #1; check("seq_8", next_PC, 32'hC);
        PC = 32'hFFFF_FFFC; #1; check("seq_wrap", next_PC, 32'h0);
        PC = 32'h0; #1; check("seq_0", next_PC, 32'h4);

        // Redirect with simultaneous done: flush wins
        PC = 32'h10; address = 32'h40; jump_branch_enable = 1'b1;
        memory_interface_data = 32'hDEAD_BEEF; memory_interface_memory_done = 1'b1;
        #1;
        check("jump_next_pc", next_PC, 32'h40);
        tick();
        check("flush_nop", fetched_instruction, NOP);
        check("flush_men", {31'b0, memory_interface_enable}, 32'h0);
        jump_branch_enable = 1'b0; memory_interface_memory_done = 1'b0;
        memory_interface_data = 32'hx; PC = 32'h40;
        tick();
        check("after_flush_men", {31'b0, memory_interface_enable}, 32'h1);
        check("after_flush_nop", fetched_instruction, NOP);
        memory_interface_data = 32'h00A0_0113; memory_interface_memory_done = 1'b1;
        tick();
        check("capture2", fetched_instruction, 32'h00A0_0113);

        // Stall with done in the same cycle: not captured
        enable = 1'b0; memory_interface_data = 32'h1111_1111;
        tick();
        check("stall_hold", fetched_instruction, 32'h00A0_0113);
        check("stall_men", {31'b0, memory_interface_enable}, 32'h0);
        memory_interface_data = 32'h2222_2222;
        tick();
        check("idle_done_ignored", fetched_instruction, 32'h00A0_0113);
        memory_interface_memory_done = 1'b0; memory_interface_data = 32'hx;
        enable = 1'b1;
        tick();
        check("resume_men", {31'b0, memory_interface_enable}, 32'h1);
        memory_interface_data = 32'h3333_3333; memory_interface_memory_done = 1'b1;
        tick();
        check("resume_capture", fetched_instruction, 32'h3333_3333);
        memory_interface_memory_done = 1'b0; memory_interface_data = 32'hx;

        // Done pulse shorter than a clock period, between edges: missed
        memory_interface_data = 32'h5555_5555; memory_interface_memory_done = 1'b1;
        #3;
        memory_interface_memory_done = 1'b0; memory_interface_data = 32'hx;
        tick();
        check("short_pulse_missed", fetched_instruction, 32'h3333_3333);

        // Reset mid-transfer, then a late done while IDLE
        reset = 1'b1; memory_interface_data = 32'h4444_4444; memory_interface_memory_done = 1'b1;
        #1;
        check("rst_mid_men_comb", {31'b0, memory_interface_enable}, 32'h0);
        check("rst_mid_mask_comb", {28'b0, memory_interface_frame_mask}, 32'h0);
        tick();
        check("rst_mid_fetched", fetched_instruction, NOP);
        reset = 1'b0; enable = 1'b0;
        tick();
        check("late_done_ignored", fetched_instruction, NOP);
        check("late_done_men", {31'b0, memory_interface_enable}, 32'h0);
        memory_interface_memory_done = 1'b0; memory_interface_data = 32'hx;

`ifdef FETCH_ALIGN_CHECK_EN
        // Misaligned PC while fetching
        enable = 1'b1; PC = 32'h0;
        tick();
        memory_interface_data = 32'h6666_6666; memory_interface_memory_done = 1'b1;
        tick();
        check("align_capture", fetched_instruction, 32'h6666_6666);
        memory_interface_memory_done = 1'b0; memory_interface_data = 32'hx;
        PC = 32'h2;
        #1;
        check("misaligned_flag", {31'b0, fetch_misaligned}, 32'h1);
        check("misaligned_men", {31'b0, memory_interface_enable}, 32'h0);
        tick();
        check("misaligned_nop", fetched_instruction, NOP);
        PC = 32'h4;
        #1;
        check("aligned_flag", {31'b0, fetch_misaligned}, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
